// File: rtl/inst_fetch.sv
// Byte-serial instruction fetch: gathers four single-byte reads into one 32-bit
// little-endian instruction, with branch flush/drain and an IF/ID valid/ready handshake.
module inst_fetch #(
    parameter int          MEM_LAT_MAX = 15,
    parameter logic [31:0] RST_PC      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        branch_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [7:0]  mem_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] pc_next_o,
    output logic        stall_req_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    // The memory latency bound belongs to the environment; the fetch logic never counts it.
    if (MEM_LAT_MAX > 0) begin : g_mem_lat_bound
    end

    state_t      state_r, state_s;
    logic [1:0]  cnt_r, cnt_s;
    logic [31:0] pc_r, pc_s;
    logic [31:0] inst_r, inst_s;
    logic        mem_req_r;
    logic        valid_r;

    function automatic logic [31:0] byte_insert(input logic [31:0] word,
                                                input logic [1:0]  idx,
                                                input logic [7:0]  data);
        logic [31:0] res;
        res = word;
        case (idx)
            2'd0:    res[7:0]   = data;
            2'd1:    res[15:8]  = data;
            2'd2:    res[23:16] = data;
            2'd3:    res[31:24] = data;
            default: res        = word;
        endcase
        return res;
    endfunction

    // Next-state, byte counter, PC latch and instruction assembly.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        pc_s    = pc_r;
        inst_s  = inst_r;
        case (state_r)
            S_IDLE: begin
                pc_s    = pc_i;
                cnt_s   = 2'd0;
                state_s = S_ISSUE;
            end
            S_ISSUE: begin
                if (branch_i) begin
                    state_s = S_IDLE;
                end else if (mem_gnt_i) begin
                    state_s = S_WAIT;
                end else begin
                    state_s = S_ISSUE;
                end
            end
            S_WAIT: begin
                // A byte landing together with a flush is already consumed, so no drain is needed.
                if (branch_i) begin
                    if (mem_rvalid_i) begin
                        state_s = S_IDLE;
                    end else begin
                        state_s = S_DRAIN;
                    end
                end else if (mem_rvalid_i) begin
                    inst_s = byte_insert(inst_r, cnt_r, mem_rdata_i);
                    if (cnt_r == 2'd3) begin
                        state_s = S_DONE;
                    end else begin
                        cnt_s   = cnt_r + 2'd1;
                        state_s = S_ISSUE;
                    end
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_DONE: begin
                if (branch_i) begin
                    state_s = S_IDLE;
                end else if (ready_i) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_DONE;
                end
            end
            S_DRAIN: begin
                if (mem_rvalid_i) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_DRAIN;
                end
            end
            default: begin
                state_s = S_IDLE;
                cnt_s   = 2'd0;
            end
        endcase
    end

    // State and output registers; request and valid are decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            cnt_r     <= 2'd0;
            pc_r      <= RST_PC;
            inst_r    <= 32'h0000_0000;
            mem_req_r <= 1'b0;
            valid_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            pc_r      <= pc_s;
            inst_r    <= inst_s;
            mem_req_r <= (state_s == S_ISSUE);
            valid_r   <= (state_s == S_DONE);
        end
    end

    assign mem_req_o   = mem_req_r;
    assign mem_addr_o  = pc_r + {30'd0, cnt_r};
    assign inst_o      = inst_r;
    assign pc_o        = pc_r;
    assign valid_o     = valid_r;
    assign pc_next_o   = pc_r + 32'd4;
    assign stall_req_o = ~(valid_r & ready_i);

endmodule
